// File: rtl/stepper_phase_sequencer.sv
// Stepper phase sequencer: accepts step commands over a valid/ready
// handshake and walks a one-hot four-phase drive at a fixed step period,
// tracking remaining steps and a signed absolute position.
//
// Handshake: cmd_ready is high only in IDLE. A command transfers on any
// clk_sys edge where cmd_valid && cmd_ready. cmd_valid is ignored in RUN,
// and the command fields are sampled only on the transfer edge.
module stepper_phase_sequencer #(
  parameter int CNT_W      = 16,
  parameter int DIV_W      = 16,
  parameter int MIN_PERIOD = 4
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  input  logic             hold_en,
  output logic [3:0]       ph_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left,
  output logic [CNT_W-1:0] position,
  output logic             state_dbg
);

  localparam logic [DIV_W-1:0] MIN_P = DIV_W'(MIN_PERIOD);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [DIV_W-1:0] timer_q, timer_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [3:0]       ph_q, ph_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [DIV_W-1:0] eff_period;

  // Next-state, step timing and registered-output values
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    period_d   = period_q;
    dir_d      = dir_q;
    steps_d    = steps_q;
    pos_d      = pos_q;
    done_d     = 1'b0;
    eff_period = (cmd_period < MIN_P) ? MIN_P : cmd_period;

    case (state_q)
      IDLE: begin
        // abort is irrelevant here, including on the accept edge
        if (cmd_valid) begin
          dir_d    = cmd_dir;
          period_d = eff_period;
          steps_d  = cmd_steps;
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            timer_d = eff_period - DIV_W'(1);
          end
        end
      end
      RUN: begin
        if (abort) begin
          // abort beats a coincident step event
          state_d = IDLE;
        end else if (timer_q == '0) begin
          idx_d   = dir_q ? idx_q + 2'd1 : idx_q - 2'd1;
          pos_d   = dir_q ? pos_q + CNT_W'(1) : pos_q - CNT_W'(1);
          timer_d = period_q - DIV_W'(1);
          if (steps_q != '0) begin
            steps_d = steps_q - CNT_W'(1);
          end
          if (steps_q <= CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          timer_d = timer_q - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    ph_d   = (state_d == RUN || hold_en) ? (4'b0001 << idx_d) : 4'b0000;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      timer_q  <= '0;
      period_q <= MIN_P;
      dir_q    <= 1'b1;
      steps_q  <= '0;
      pos_q    <= '0;
      ph_q     <= 4'b0000;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      period_q <= period_d;
      dir_q    <= dir_d;
      steps_q  <= steps_d;
      pos_q    <= pos_d;
      ph_q     <= ph_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign ph_out     = ph_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign steps_left = steps_q;
  assign position   = pos_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// Directed bench for stepper_phase_sequencer. A second, 8-bit-count
// instance exercises position wrap within a short run.
module tb_stepper_phase_sequencer;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_dir, abort, hold_en;
  logic [15:0] cmd_steps, cmd_period;
  logic        cmd_ready, busy, done, state_dbg;
  logic [3:0]  ph_out;
  logic [15:0] steps_left, position;

  logic        w_valid, w_dir;
  logic [7:0]  w_steps;
  logic [15:0] w_period;
  logic        w_ready, w_busy, w_done, w_state;
  logic [3:0]  w_ph;
  logic [7:0]  w_left, w_pos;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_sys = ~clk_sys;

  stepper_phase_sequencer u_dut (
    .clk_sys(clk_sys), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .abort(abort), .hold_en(hold_en), .ph_out(ph_out), .busy(busy),
    .done(done), .steps_left(steps_left), .position(position),
    .state_dbg(state_dbg)
  );

  stepper_phase_sequencer #(.CNT_W(8)) u_dut_w8 (
    .clk_sys(clk_sys), .rst(rst), .cmd_valid(w_valid), .cmd_ready(w_ready),
    .cmd_dir(w_dir), .cmd_steps(w_steps), .cmd_period(w_period),
    .abort(1'b0), .hold_en(1'b1), .ph_out(w_ph), .busy(w_busy),
    .done(w_done), .steps_left(w_left), .position(w_pos),
    .state_dbg(w_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    check_eq("rst_ph", 32'(ph_out), 32'h0);
    check_eq("rst_pos", 32'(position), 32'h0);
    check_eq("rst_left", 32'(steps_left), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    rst = 1'b0;
  endtask

  // Issue one command and check every cycle until the run finishes.
  task automatic run_cmd(input logic dir, input int steps, input int period, input int idx0);
    int eff, total, n, idx;
    logic [3:0] exp_ph;
    eff   = (period < 4) ? 4 : period;
    total = eff * steps;
    cmd_valid = 1'b1; cmd_dir = dir;
    cmd_steps = 16'(steps); cmd_period = 16'(period);
    tick();
    cmd_valid = 1'b0;
    check_eq("acc_busy", 32'(busy), 32'h1);
    check_eq("acc_ready", 32'(cmd_ready), 32'h0);
    check_eq("acc_left", 32'(steps_left), 32'(steps));
    for (int k = 1; k <= total; k++) begin
      tick();
      n      = k / eff;
      idx    = dir ? ((idx0 + n) % 4) : ((((idx0 - n) % 4) + 4) % 4);
      exp_ph = 4'b0001 << idx;
      check_eq($sformatf("run_ph_k%0d", k), 32'(ph_out), 32'(exp_ph));
      check_eq($sformatf("run_busy_k%0d", k), 32'(busy), 32'(k < total));
      check_eq($sformatf("run_done_k%0d", k), 32'(done), 32'(k == total));
      check_eq($sformatf("run_left_k%0d", k), 32'(steps_left), 32'(steps - n));
    end
    tick();
    check_eq("post_done", 32'(done), 32'h0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b1; abort = 1'b0; hold_en = 1'b1;
    cmd_steps = '0; cmd_period = '0;
    w_valid = 1'b0; w_dir = 1'b1; w_steps = '0; w_period = 16'd4;

    // forward run, 4 steps every 10 cycles
    do_reset();
    tick();
    check_eq("idle_hold_ph", 32'(ph_out), 32'h1);
    check_eq("idle_ready", 32'(cmd_ready), 32'h1);
    run_cmd(1'b1, 4, 10, 0);
    check_eq("fwd_pos", 32'(position), 32'h4);
    check_eq("fwd_left", 32'(steps_left), 32'h0);
    check_eq("fwd_ph", 32'(ph_out), 32'h1);

    // reverse run with period clamped to 4
    do_reset();
    tick();
    run_cmd(1'b0, 3, 1, 0);
    check_eq("rev_pos", 32'(position), 32'hFFFD);
    check_eq("rev_ph", 32'(ph_out), 32'h2);

    // abort on the cycle the timer reaches 0 before the third step
    do_reset();
    tick();
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd10; cmd_period = 16'd8;
    tick();
    cmd_valid = 1'b0;
    repeat (23) tick();
    check_eq("abort_pre_pos", 32'(position), 32'h2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'h0);
    check_eq("abort_done", 32'(done), 32'h0);
    check_eq("abort_left", 32'(steps_left), 32'h8);
    check_eq("abort_pos", 32'(position), 32'h2);
    check_eq("abort_ph", 32'(ph_out), 32'h4);
    check_eq("abort_ready", 32'(cmd_ready), 32'h1);
    tick();
    check_eq("abort_done2", 32'(done), 32'h0);

    // abort in IDLE does nothing
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("idle_abort_ph", 32'(ph_out), 32'h4);
    check_eq("idle_abort_pos", 32'(position), 32'h2);

    // zero-step command
    cmd_valid = 1'b1; cmd_steps = 16'd0; cmd_period = 16'd5;
    tick();
    cmd_valid = 1'b0;
    check_eq("zero_done", 32'(done), 32'h1);
    check_eq("zero_busy", 32'(busy), 32'h0);
    check_eq("zero_ph", 32'(ph_out), 32'h4);
    check_eq("zero_pos", 32'(position), 32'h2);
    check_eq("zero_left", 32'(steps_left), 32'h0);
    tick();
    check_eq("zero_done2", 32'(done), 32'h0);

    // cmd_valid held through RUN, abort on the accept edge is ignored
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd2; cmd_period = 16'd4;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("hv_busy", 32'(busy), 32'h1);
    cmd_steps = 16'd1;
    repeat (7) tick();
    check_eq("hv_left_k7", 32'(steps_left), 32'h1);
    check_eq("hv_busy_k7", 32'(busy), 32'h1);
    tick();
    check_eq("hv_done_k8", 32'(done), 32'h1);
    check_eq("hv_ready_k8", 32'(cmd_ready), 32'h1);
    check_eq("hv_pos_k8", 32'(position), 32'h4);
    tick();
    cmd_valid = 1'b0;
    check_eq("hv_reacc_busy", 32'(busy), 32'h1);
    check_eq("hv_reacc_left", 32'(steps_left), 32'h1);
    repeat (4) tick();
    check_eq("hv2_done", 32'(done), 32'h1);
    check_eq("hv2_pos", 32'(position), 32'h5);
    check_eq("hv2_ph", 32'(ph_out), 32'h2);

    // hold_en toggle in IDLE
    hold_en = 1'b0;
    tick();
    check_eq("hold_off_ph", 32'(ph_out), 32'h0);
    hold_en = 1'b1;
    tick();
    check_eq("hold_on_ph", 32'(ph_out), 32'h2);

    // RUN drives the phase even with hold_en low
    hold_en = 1'b0;
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 16'd1; cmd_period = 16'd4;
    tick();
    cmd_valid = 1'b0;
    check_eq("run_nohold_ph", 32'(ph_out), 32'h2);
    repeat (4) tick();
    check_eq("run_nohold_end_ph", 32'(ph_out), 32'h0);
    check_eq("run_nohold_pos", 32'(position), 32'h4);
    hold_en = 1'b1;
    tick();
    check_eq("rehold_ph", 32'(ph_out), 32'h1);

    // reset in the middle of a run
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd5; cmd_period = 16'd4;
    tick();
    cmd_valid = 1'b0;
    repeat (6) tick();
    check_eq("mid_busy", 32'(busy), 32'h1);
    do_reset();
    tick();
    check_eq("mid_after_ph", 32'(ph_out), 32'h1);
    check_eq("mid_after_done", 32'(done), 32'h0);

    // position wrap on the 8-bit instance: 127 forward steps then one more
    w_valid = 1'b1; w_dir = 1'b1; w_steps = 8'd127; w_period = 16'd4;
    tick();
    w_valid = 1'b0;
    repeat (508) tick();
    check_eq("w8_done", 32'(w_done), 32'h1);
    check_eq("w8_pos_7f", 32'(w_pos), 32'h7F);
    w_valid = 1'b1; w_steps = 8'd1;
    tick();
    w_valid = 1'b0;
    repeat (4) tick();
    check_eq("w8_pos_80", 32'(w_pos), 32'h80);
    check_eq("w8_left", 32'(w_left), 32'h0);
    check_eq("w8_ph", 32'(w_ph), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
